// File: rtl/opl_write_sequencer.sv
// opl_write_sequencer: buffers AdLib port writes in a FIFO and replays them to
// the OPL2 write port, inserting register-settle delays counted in OPL clock
// enables after each index (A0=0) or data (A0=1) write.
module opl_write_sequencer #(
   parameter logic [11:0] BASE       = 12'h388,
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned ADDR_WAIT  = 12,
   parameter int unsigned DATA_WAIT  = 84
) (
   input  logic                  iClk,
   input  logic                  iRstN,
   input  logic                  iClkEn,
   input  logic                  iWr,
   input  logic [7:0]            iWrData,
   input  logic [19:0]           iAddr,
   input  logic                  iOvfClr,
   output logic [7:0]            oOplDin,
   output logic                  oOplAddr,
   output logic                  oOplWrN,
   output logic [DEPTH_LOG2:0]   oLevel,
   output logic                  oBusy,
   output logic                  oOvf
);

   localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
   localparam int unsigned PW    = DEPTH_LOG2 + 1;
   localparam int unsigned WMAX  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
   localparam int unsigned CW    = (WMAX == 0) ? 1 : $clog2(WMAX + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [8:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW-1:0] r_level;
   logic          r_ovf;
   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          r_wrn;
   logic [7:0]    r_din;
   logic          r_a0;

   logic          w_hit;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_wait_load;
   logic          w_unused;

   // Bus decode: only the low 12 address bits take part, A0 selects index/data
   assign w_hit       = iWr & ({iAddr[11:1], 1'b0} == BASE);
   assign w_full      = (r_level == PW'(DEPTH));
   assign w_empty     = (r_level == '0);
   assign w_push      = w_hit & ~w_full;
   assign w_pop       = (r_state == S_IDLE) & ~w_empty;
   assign w_wait_load = r_a0 ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
   assign w_unused    = &{1'b0, iAddr[19:12]};

   // FIFO storage, written on an accepted push
   always_ff @(posedge iClk) begin
      if (w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= {iAddr[0], iWrData};
   end

   // FIFO pointers and occupancy; fullness uses the pre-edge level
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + PW'(1);
            2'b01:   r_level <= r_level - PW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Sticky overflow: a dropped push beats a coincident clear
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN)               r_ovf <= 1'b0;
      else if (w_hit & w_full)  r_ovf <= 1'b1;
      else if (iOvfClr)         r_ovf <= 1'b0;
   end

   // Sequencer state register
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state: pop when idle, one issue cycle, then count enable pulses
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (!w_empty) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = (w_wait_load == '0) ? S_IDLE : S_WAIT;
         S_WAIT:  if (iClkEn && (r_cnt <= CW'(1))) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Write strobe, held output data and settle counter
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_wrn <= 1'b1;
         r_din <= '0;
         r_a0  <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_wrn <= ~w_pop;
         if (w_pop) {r_a0, r_din} <= r_mem[r_rptr[DEPTH_LOG2-1:0]];
         if (r_state == S_ISSUE)
            r_cnt <= w_wait_load;
         else if ((r_state == S_WAIT) && iClkEn && (r_cnt != '0))
            r_cnt <= r_cnt - CW'(1);
      end
   end

   assign oOplDin  = r_din;
   assign oOplAddr = r_a0;
   assign oOplWrN  = r_wrn;
   assign oLevel   = r_level;
   assign oOvf     = r_ovf;
   assign oBusy    = (r_state != S_IDLE) | (r_level != '0);

endmodule

// File: tb/tb_opl_write_sequencer.sv
// Bench for opl_write_sequencer: random data against a queue-based reference model.
module tb_opl_write_sequencer;

   localparam int T_ADDR_WAIT = 12;
   localparam int T_DATA_WAIT = 84;
   localparam int T_DEPTH     = 16;

   logic        clk = 1'b0;
   logic        iRstN = 1'b0;
   logic        iClkEn = 1'b0;
   logic        iWr = 1'b0;
   logic [7:0]  iWrData = '0;
   logic [19:0] iAddr = '0;
   logic        iOvfClr = 1'b0;

   logic [7:0]  oOplDin;
   logic        oOplAddr, oOplWrN, oBusy, oOvf;
   logic [4:0]  oLevel;
   logic [7:0]  z_din;
   logic        z_addr, z_wrn, z_busy, z_ovf;
   logic [4:0]  z_level;

   int n_err = 0;
   int n_chk = 0;
   int en_period = 1;
   int en_cnt = 0;
   int pulse_total = 0;
   logic [8:0] seen_q[$];

   opl_write_sequencer u_dut (
      .iClk(clk), .iRstN(iRstN), .iClkEn(iClkEn), .iWr(iWr), .iWrData(iWrData),
      .iAddr(iAddr), .iOvfClr(iOvfClr), .oOplDin(oOplDin), .oOplAddr(oOplAddr),
      .oOplWrN(oOplWrN), .oLevel(oLevel), .oBusy(oBusy), .oOvf(oOvf));

   opl_write_sequencer #(.ADDR_WAIT(0), .DATA_WAIT(0)) u_dz (
      .iClk(clk), .iRstN(iRstN), .iClkEn(iClkEn), .iWr(iWr), .iWrData(iWrData),
      .iAddr(iAddr), .iOvfClr(iOvfClr), .oOplDin(z_din), .oOplAddr(z_addr),
      .oOplWrN(z_wrn), .oLevel(z_level), .oBusy(z_busy), .oOvf(z_ovf));

   always #5 clk = ~clk;

   // Reference model: pending queue, issue slot busy for one cycle plus W enable pulses
   logic [8:0] mq[$];
   bit         m_free = 1'b1;
   int         m_hold = 0;
   int         m_rem = 0;
   bit         m_ovf = 1'b0;
   bit         m_strobe = 1'b0;
   logic [8:0] m_out = '0;

   always @(posedge clk or negedge iRstN) begin
      if (!iRstN) begin
         mq.delete();
         m_free = 1'b1; m_hold = 0; m_rem = 0;
         m_ovf = 1'b0; m_strobe = 1'b0; m_out = '0;
      end else begin
         bit hit;
         bit full;
         int sz;
         sz   = mq.size();
         full = (sz == T_DEPTH);
         hit  = iWr && (iAddr[11:0] == 12'h388 || iAddr[11:0] == 12'h389);
         m_strobe = 1'b0;
         if (m_free && sz > 0) begin
            m_out = mq.pop_front();
            m_strobe = 1'b1;
            m_free = 1'b0;
            m_hold = 1;
            m_rem = m_out[8] ? T_DATA_WAIT : T_ADDR_WAIT;
         end else if (!m_free) begin
            if (m_hold != 0) begin
               m_hold = 0;
               if (m_rem == 0) m_free = 1'b1;
            end else if (iClkEn) begin
               m_rem = m_rem - 1;
               if (m_rem == 0) m_free = 1'b1;
            end
         end
         if (hit && !full) mq.push_back({iAddr[0], iWrData});
         if (hit && full) m_ovf = 1'b1;
         else if (iOvfClr) m_ovf = 1'b0;
      end
   end

   function automatic bit m_busy();
      return !m_free || (mq.size() != 0);
   endfunction

   // Enable-pulse counter and strobe collector
   always @(posedge clk) if (iClkEn) pulse_total = pulse_total + 1;
   always @(negedge clk) if (iRstN && oOplWrN === 1'b0) seen_q.push_back({oOplAddr, oOplDin});

   // Advance to the next falling edge and set the enable for the coming rising edge
   task automatic tick();
      @(negedge clk);
      en_cnt = en_cnt + 1;
      iClkEn = ((en_cnt % en_period) == 0);
   endtask

   task automatic test_reset();
      iRstN = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if (oOplWrN !== 1'b1) begin n_err++; $display("FAIL reset_wrn got=%b exp=1", oOplWrN); end
      n_chk++; if (oOplDin !== 8'h00) begin n_err++; $display("FAIL reset_din got=%h exp=00", oOplDin); end
      n_chk++; if (oOplAddr !== 1'b0) begin n_err++; $display("FAIL reset_addr got=%b exp=0", oOplAddr); end
      n_chk++; if (oLevel !== 5'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", oLevel); end
      n_chk++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", oBusy); end
      n_chk++; if (oOvf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", oOvf); end
      n_chk++; if ({z_wrn, z_busy, z_level} !== 7'b1000000) begin n_err++; $display("FAIL reset_zdut got=%b exp=1000000", {z_wrn, z_busy, z_level}); end
      iRstN = 1'b1;
      tick();
   endtask

   task automatic test_single_index();
      int base;
      bit done;
      en_period = int'($urandom_range(1, 3));
      tick();
      iWr = 1'b1; iAddr = 20'h00388; iWrData = 8'h20;
      tick();
      iWr = 1'b0;
      n_chk++; if (oLevel !== 5'd1 || oOplWrN !== 1'b1) begin n_err++; $display("FAIL single_push got=lvl%0d/wrn%b exp=lvl1/wrn1", oLevel, oOplWrN); end
      tick();
      n_chk++; if ({oOplWrN, oOplAddr, oOplDin} !== 10'b0_0_00100000) begin n_err++; $display("FAIL single_strobe got=%b/%b/%h exp=0/0/20", oOplWrN, oOplAddr, oOplDin); end
      tick();
      n_chk++; if (oOplWrN !== 1'b1 || oBusy !== 1'b1) begin n_err++; $display("FAIL single_release got=wrn%b/busy%b exp=wrn1/busy1", oOplWrN, oBusy); end
      base = pulse_total;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         tick();
         n_chk++;
         if ({oOplWrN, oOplAddr, oOplDin, oLevel, oBusy, oOvf} !== {~m_strobe, m_out, 5'(mq.size()), m_busy(), m_ovf}) begin
            n_err++; $display("FAIL single_model cyc=%0d got=%h exp=%h", i, {oOplWrN, oOplAddr, oOplDin, oLevel, oBusy, oOvf}, {~m_strobe, m_out, 5'(mq.size()), m_busy(), m_ovf});
         end
         if (oBusy === 1'b0) done = 1'b1;
      end
      n_chk++; if (!done || (pulse_total - base) != T_ADDR_WAIT) begin n_err++; $display("FAIL single_wait got=%0d pulses exp=%0d", pulse_total - base, T_ADDR_WAIT); end
   endtask

   task automatic test_pair();
      int ns;
      int p_s[2];
      int base2;
      bit arm2;
      bit done;
      logic [8:0] vals[2];
      en_period = 3;
      ns = 0; base2 = 0; arm2 = 1'b0; done = 1'b0;
      tick();
      iWr = 1'b1; iAddr = 20'h00388; iWrData = 8'hA0;
      tick();
      iAddr = 20'h00389; iWrData = 8'h44;
      tick();
      iWr = 1'b0;
      for (int i = 0; i < 1000 && !done; i++) begin
         n_chk++;
         if ({oOplWrN, oOplAddr, oOplDin, oLevel, oBusy, oOvf} !== {~m_strobe, m_out, 5'(mq.size()), m_busy(), m_ovf}) begin
            n_err++; $display("FAIL pair_model cyc=%0d got=%h exp=%h", i, {oOplWrN, oOplAddr, oOplDin, oLevel, oBusy, oOvf}, {~m_strobe, m_out, 5'(mq.size()), m_busy(), m_ovf});
         end
         if (arm2) begin base2 = pulse_total; arm2 = 1'b0; end
         if (oOplWrN === 1'b0 && ns < 2) begin
            p_s[ns] = pulse_total; vals[ns] = {oOplAddr, oOplDin};
            ns++;
            if (ns == 2) arm2 = 1'b1;
         end
         if (ns == 2 && !arm2 && oBusy === 1'b0) done = 1'b1;
         else tick();
      end
      n_chk++; if (ns != 2) begin n_err++; $display("FAIL pair_count got=%0d exp=2", ns); end
      if (ns == 2) begin
         n_chk++; if (vals[0] !== 9'h0A0 || vals[1] !== 9'h144) begin n_err++; $display("FAIL pair_values got=%h,%h exp=0a0,144", vals[0], vals[1]); end
         n_chk++; if ((p_s[1] - p_s[0]) < T_ADDR_WAIT) begin n_err++; $display("FAIL pair_spacing got=%0d pulses exp>=%0d", p_s[1] - p_s[0], T_ADDR_WAIT); end
         n_chk++; if (!done || (pulse_total - base2) != T_DATA_WAIT) begin n_err++; $display("FAIL pair_data_wait got=%0d pulses exp=%0d", pulse_total - base2, T_DATA_WAIT); end
      end
   endtask

   task automatic test_decode();
      logic [19:0] adr[3];
      logic        wr[3];
      adr[0] = 20'h0038A; wr[0] = 1'b1;
      adr[1] = 20'h00288; wr[1] = 1'b1;
      adr[2] = 20'h00389; wr[2] = 1'b0;
      en_period = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         iWr = wr[i]; iAddr = adr[i]; iWrData = 8'($urandom);
         tick();
         iWr = 1'b0;
         n_chk++; if (oLevel !== 5'd0 || oOplWrN !== 1'b1 || oBusy !== 1'b0) begin n_err++; $display("FAIL decode_%0d got=lvl%0d/wrn%b/busy%b exp=lvl0/wrn1/busy0", i, oLevel, oOplWrN, oBusy); end
         tick();
         n_chk++; if (oOplWrN !== 1'b1) begin n_err++; $display("FAIL decode_strobe_%0d got=%b exp=1", i, oOplWrN); end
      end
   endtask

   task automatic test_overflow();
      logic [8:0] ent[18];
      int peak;
      bit done;
      en_period = 1;
      ent[0] = {1'b1, 8'($urandom)};
      for (int i = 1; i < 18; i++) ent[i] = 9'($urandom);
      peak = 0; done = 1'b0;
      tick();
      seen_q.delete();
      for (int i = 0; i < 18; i++) begin
         iWr = 1'b1; iAddr = {19'h001C4, ent[i][8]}; iWrData = ent[i][7:0];
         tick();
         if (int'(oLevel) > peak) peak = int'(oLevel);
      end
      iWr = 1'b0;
      n_chk++; if (peak != T_DEPTH || oOvf !== 1'b1) begin n_err++; $display("FAIL ovf_peak got=lvl%0d/ovf%b exp=lvl16/ovf1", peak, oOvf); end
      iOvfClr = 1'b1;
      tick();
      iOvfClr = 1'b0;
      n_chk++; if (oOvf !== 1'b0 || oLevel !== 5'd16) begin n_err++; $display("FAIL ovf_clear got=ovf%b/lvl%0d exp=ovf0/lvl16", oOvf, oLevel); end
      tick();
      iWr = 1'b1; iAddr = 20'h00388; iWrData = 8'($urandom); iOvfClr = 1'b1;
      tick();
      iWr = 1'b0; iOvfClr = 1'b0;
      n_chk++; if (oOvf !== 1'b1 || oLevel !== 5'd16) begin n_err++; $display("FAIL ovf_set_wins got=ovf%b/lvl%0d exp=ovf1/lvl16", oOvf, oLevel); end
      iOvfClr = 1'b1;
      tick();
      iOvfClr = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         tick();
         n_chk++;
         if ({oOplWrN, oOplAddr, oOplDin, oLevel, oBusy, oOvf} !== {~m_strobe, m_out, 5'(mq.size()), m_busy(), m_ovf}) begin
            n_err++; $display("FAIL ovf_model cyc=%0d got=%h exp=%h", i, {oOplWrN, oOplAddr, oOplDin, oLevel, oBusy, oOvf}, {~m_strobe, m_out, 5'(mq.size()), m_busy(), m_ovf});
         end
         if (oBusy === 1'b0) done = 1'b1;
      end
      n_chk++; if (!done || seen_q.size() != 17) begin n_err++; $display("FAIL ovf_strobe_count got=%0d exp=17", seen_q.size()); end
      for (int i = 0; i < 17 && i < seen_q.size(); i++) begin
         n_chk++; if (seen_q[i] !== ent[i]) begin n_err++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, seen_q[i], ent[i]); end
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [8:0] ent[6];
      en_period = 1;
      ent[0] = {1'b1, 8'($urandom) | 8'h01};
      for (int i = 1; i < 6; i++) ent[i] = 9'($urandom);
      tick();
      for (int i = 0; i < 6; i++) begin
         iWr = 1'b1; iAddr = {19'h001C4, ent[i][8]}; iWrData = ent[i][7:0];
         tick();
      end
      iWr = 1'b0;
      repeat (5 + int'($urandom_range(0, 20))) tick();
      n_chk++; if (oLevel !== 5'd5 || oBusy !== 1'b1 || oOplDin !== ent[0][7:0]) begin n_err++; $display("FAIL mid_pre got=lvl%0d/busy%b/din%h exp=lvl5/busy1/din%h", oLevel, oBusy, oOplDin, ent[0][7:0]); end
      #2 iRstN = 1'b0;
      #1;
      n_chk++;
      if ({oOplWrN, oOplAddr, oOplDin, oLevel, oBusy, oOvf} !== {1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL mid_async_reset got=%b exp=%b", {oOplWrN, oOplAddr, oOplDin, oLevel, oBusy, oOvf}, {1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0});
      end
      tick();
      tick();
      iRstN = 1'b1;
      seen_q.delete();
      for (int i = 0; i < 150; i++) begin
         tick();
         n_chk++; if (oOplWrN !== 1'b1 || oLevel !== 5'd0 || oBusy !== 1'b0) begin n_err++; $display("FAIL mid_after cyc=%0d got=wrn%b/lvl%0d/busy%b exp=wrn1/lvl0/busy0", i, oOplWrN, oLevel, oBusy); end
      end
      n_chk++; if (seen_q.size() != 0) begin n_err++; $display("FAIL mid_no_strobes got=%0d exp=0", seen_q.size()); end
   endtask

   task automatic test_zero_wait();
      logic [8:0] zent[4];
      bit exp_low;
      int idx;
      en_period = 1;
      for (int i = 0; i < 4; i++) zent[i] = 9'($urandom);
      tick();
      for (int j = 0; j < 12; j++) begin
         if (j < 4) begin iWr = 1'b1; iAddr = {19'h001C4, zent[j][8]}; iWrData = zent[j][7:0]; end
         else iWr = 1'b0;
         tick();
         exp_low = (j % 2 == 1) && (j <= 7);
         idx = (j - 1) / 2;
         n_chk++; if (z_wrn !== ~exp_low) begin n_err++; $display("FAIL zero_strobe j=%0d got=%b exp=%b", j, z_wrn, ~exp_low); end
         if (exp_low) begin
            n_chk++; if ({z_addr, z_din} !== zent[idx]) begin n_err++; $display("FAIL zero_value j=%0d got=%h exp=%h", j, {z_addr, z_din}, zent[idx]); end
         end
         n_chk++; if (z_busy !== (j < 8)) begin n_err++; $display("FAIL zero_busy j=%0d got=%b exp=%b", j, z_busy, (j < 8)); end
      end
      iWr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_index();
      test_pair();
      test_decode();
      test_overflow();
      test_reset_mid_wait();
      test_zero_wait();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
